pipeline_sequencer: RTL and testbench

Parametrised pipeline sequencer for the maxicore32 two-stage pipeline. It generalises the NOP-insertion and halt-counting control of the core to configurable flush and halt-drain lengths. It adds a bus wait-state handshake (`bus_ready`) and saturating stall/bubble performance counters. It sits between the bus interface, memorystage1 and the program counter, and decides each cycle whether to issue the fetched word or a NOP, and whether the pipeline advances.

---
 rtl/pipeline_sequencer_pkg.sv | 20 ++
 rtl/pipeline_sequencer_sat_counter.sv | 19 +
 rtl/pipeline_sequencer.sv | 111 +++++++++++
 tb/tb_pipeline_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the maxicore32 pipeline sequencer.
package pipeline_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_HALTING,
    ST_HALTED
  } seq_state_t;

  localparam logic [4:0] OPCODE_NOP = 5'h00;

  // Bits needed to hold values 0..max_value, never less than one.
  function automatic int count_bits(input int max_value);
    int bits;
    bits = $clog2(max_value + 1);
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Decides each cycle whether the fetched word or a NOP is issued and whether
// the two-stage pipeline advances; tracks flushes, halt drain and stall/bubble counts.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int FLUSH_CYCLES      = 2,
  parameter int HALT_DRAIN_CYCLES = 4,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   bus_ready,
  input  logic                   memory_access_cycle,
  input  logic                   control_flow_start_cycle,
  input  logic                   halting,
  input  logic [DATA_WIDTH-1:0]  fetch_data,
  output logic [DATA_WIDTH-1:0]  issue_instruction,
  output logic                   stage_enable,
  output logic                   pc_inc,
  output logic                   fetch_select,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] stall_count,
  output logic [COUNT_WIDTH-1:0] bubble_count
);

  localparam int FLUSH_W = count_bits(FLUSH_CYCLES);
  localparam int DRAIN_W = count_bits(HALT_DRAIN_CYCLES);
  localparam logic [FLUSH_W-1:0] FLUSH_RELOAD = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST   = DRAIN_W'(HALT_DRAIN_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] NOP_WORD  = {OPCODE_NOP, {(DATA_WIDTH-5){1'b0}}};

  seq_state_t         state;
  logic [FLUSH_W-1:0] flush_left;
  logic [DRAIN_W-1:0] drain_count;
  logic               insert_nop;

  always_comb begin
    stage_enable      = bus_ready & (state != ST_HALTED);
    insert_nop        = memory_access_cycle | control_flow_start_cycle | halting |
                        (state != ST_RUN);
    issue_instruction = insert_nop ? NOP_WORD : fetch_data;
    pc_inc            = stage_enable & ~insert_nop;
    fetch_select      = memory_access_cycle;
  end

  // Halting wins over control flow; a one-cycle drain skips HALTING entirely.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RUN;
      flush_left  <= '0;
      drain_count <= '0;
      halted      <= 1'b0;
    end else if (stage_enable) begin
      unique case (state)
        ST_RUN, ST_FLUSH: begin
          if (halting) begin
            if (HALT_DRAIN_CYCLES == 1) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end else begin
              state       <= ST_HALTING;
              drain_count <= DRAIN_W'(1);
            end
          end else if (control_flow_start_cycle) begin
            if (FLUSH_CYCLES > 1) begin
              state      <= ST_FLUSH;
              flush_left <= FLUSH_RELOAD;
            end
          end else if (state == ST_FLUSH) begin
            if (flush_left == FLUSH_W'(1)) begin
              state      <= ST_RUN;
              flush_left <= '0;
            end else begin
              flush_left <= flush_left - FLUSH_W'(1);
            end
          end
        end
        ST_HALTING: begin
          if (!halting) begin
            state       <= ST_RUN;
            drain_count <= '0;
          end else if (drain_count == DRAIN_LAST) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else begin
            drain_count <= drain_count + DRAIN_W'(1);
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_stall_counter (
    .clock (clock),
    .reset (reset),
    .inc   (~bus_ready & (state != ST_HALTED)),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_bubble_counter (
    .clock (clock),
    .reset (reset),
    .inc   (stage_enable & insert_nop),
    .count (bubble_count)
  );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Two sequencer configurations driven by shared directed and random stimulus,
// each compared every cycle against a streak/countdown reference model.
module tb_pipeline_sequencer;
  import pipeline_sequencer_pkg::*;

  localparam logic [31:0] NOP = {OPCODE_NOP, 27'b0};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bus_ready = 1'b0;
  logic        memory_access_cycle = 1'b0;
  logic        control_flow_start_cycle = 1'b0;
  logic        halting = 1'b0;
  logic [31:0] fetch_data = 32'h12345678;

  logic [31:0] issue_a, issue_b;
  logic        enable_a, enable_b, pc_inc_a, pc_inc_b;
  logic        select_a, select_b, halted_a, halted_b;
  logic [15:0] stall_a, bubble_a;
  logic [3:0]  stall_b, bubble_b;

  int total = 0;
  int bad = 0;
  int cycle = 0;

  int fc[2]   = '{2, 3};
  int hdc[2]  = '{4, 1};
  int cmax[2] = '{65535, 15};
  int m_flush[2]  = '{0, 0};
  int m_streak[2] = '{0, 0};
  int m_stall[2]  = '{0, 0};
  int m_bubble[2] = '{0, 0};
  bit m_halted[2] = '{0, 0};

  always #5 clock = ~clock;

  pipeline_sequencer #(
    .DATA_WIDTH(32), .FLUSH_CYCLES(2), .HALT_DRAIN_CYCLES(4), .COUNT_WIDTH(16)
  ) dut_a (
    .clock(clock), .reset(reset), .bus_ready(bus_ready),
    .memory_access_cycle(memory_access_cycle),
    .control_flow_start_cycle(control_flow_start_cycle),
    .halting(halting), .fetch_data(fetch_data),
    .issue_instruction(issue_a), .stage_enable(enable_a), .pc_inc(pc_inc_a),
    .fetch_select(select_a), .halted(halted_a),
    .stall_count(stall_a), .bubble_count(bubble_a)
  );

  pipeline_sequencer #(
    .DATA_WIDTH(32), .FLUSH_CYCLES(3), .HALT_DRAIN_CYCLES(1), .COUNT_WIDTH(4)
  ) dut_b (
    .clock(clock), .reset(reset), .bus_ready(bus_ready),
    .memory_access_cycle(memory_access_cycle),
    .control_flow_start_cycle(control_flow_start_cycle),
    .halting(halting), .fetch_data(fetch_data),
    .issue_instruction(issue_b), .stage_enable(enable_b), .pc_inc(pc_inc_b),
    .fetch_select(select_b), .halted(halted_b),
    .stall_count(stall_b), .bubble_count(bubble_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cycle, got, exp);
    end
  endtask

  task automatic checkInstance(input int i);
    logic [31:0] g_issue, g_stall, g_bubble;
    logic        g_en, g_pc, g_sel, g_halted;
    bit          en, nop;
    string       s;
    if (i == 0) begin
      g_issue = issue_a; g_en = enable_a; g_pc = pc_inc_a; g_sel = select_a;
      g_halted = halted_a; g_stall = 32'(stall_a); g_bubble = 32'(bubble_a);
    end else begin
      g_issue = issue_b; g_en = enable_b; g_pc = pc_inc_b; g_sel = select_b;
      g_halted = halted_b; g_stall = 32'(stall_b); g_bubble = 32'(bubble_b);
    end
    s = (i == 0) ? "a" : "b";
    en  = bus_ready && !m_halted[i];
    nop = memory_access_cycle || control_flow_start_cycle || halting ||
          (m_flush[i] > 0) || (m_streak[i] > 0) || m_halted[i];
    checkOutput({"issue_", s}, g_issue, nop ? NOP : fetch_data);
    checkOutput({"stage_enable_", s}, 32'(g_en), 32'(en));
    checkOutput({"pc_inc_", s}, 32'(g_pc), 32'(en && !nop));
    checkOutput({"fetch_select_", s}, 32'(g_sel), 32'(memory_access_cycle));
    checkOutput({"halted_", s}, 32'(g_halted), 32'(m_halted[i]));
    checkOutput({"stall_count_", s}, g_stall, 32'(m_stall[i]));
    checkOutput({"bubble_count_", s}, g_bubble, 32'(m_bubble[i]));
  endtask

  // Reference: NOPs owed after a branch, consecutive halting cycles, sticky halt.
  task automatic modelStep(input int i);
    bit en, nop;
    en  = bus_ready && !m_halted[i];
    nop = memory_access_cycle || control_flow_start_cycle || halting ||
          (m_flush[i] > 0) || (m_streak[i] > 0) || m_halted[i];
    if (reset) begin
      m_flush[i] = 0; m_streak[i] = 0; m_stall[i] = 0; m_bubble[i] = 0; m_halted[i] = 0;
      return;
    end
    if (!bus_ready && !m_halted[i] && m_stall[i] < cmax[i]) m_stall[i]++;
    if (en && nop && m_bubble[i] < cmax[i]) m_bubble[i]++;
    if (en) begin
      if (halting) begin
        m_streak[i]++;
        m_flush[i] = 0;
        if (m_streak[i] == hdc[i]) m_halted[i] = 1;
      end else if (m_streak[i] > 0) begin
        m_streak[i] = 0;
      end else if (control_flow_start_cycle) begin
        m_flush[i] = fc[i] - 1;
      end else if (m_flush[i] > 0) begin
        m_flush[i]--;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit br, input bit mac, input bit cfs,
                               input bit hlt, input logic [31:0] fd);
    @(posedge clock);
    #1;
    reset = r; bus_ready = br; memory_access_cycle = mac;
    control_flow_start_cycle = cfs; halting = hlt; fetch_data = fd;
    cycle++;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      checkInstance(i);
      modelStep(i);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 1, 0, 0, 0, 32'h12345678);
  endtask

  initial begin
    int hold_left;
    bit h;
    applyStimulus(1, 0, 0, 0, 0, 32'h12345678);
    applyStimulus(1, 0, 0, 0, 0, 32'h12345678);
    idle(10);
    checkOutput("idle_bubble_a", 32'(bubble_a), 32'd0);
    checkOutput("idle_stall_a", 32'(stall_a), 32'd0);

    applyStimulus(0, 1, 0, 1, 0, 32'h12345678);
    idle(5);
    checkOutput("flush_bubbles_a", 32'(bubble_a), 32'd2);
    checkOutput("flush_bubbles_b", 32'(bubble_b), 32'd3);

    applyStimulus(0, 1, 0, 1, 0, 32'h0badf00d);
    idle(1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 32'h0badf00d);
    idle(6);
    checkOutput("wait_stall_a", 32'(stall_a), 32'd3);
    checkOutput("wait_stall_b", 32'(stall_b), 32'd3);

    for (int k = 0; k < 6; k++) applyStimulus(0, 1, 0, 0, 1, 32'h11112222);
    idle(3);
    checkOutput("sticky_halt_a", 32'(halted_a), 32'd1);
    applyStimulus(1, 1, 0, 0, 0, 32'h12345678);
    idle(2);
    checkOutput("reset_unhalt_a", 32'(halted_a), 32'd0);

    for (int k = 0; k < 2; k++) applyStimulus(0, 1, 0, 0, 1, 32'h33334444);
    idle(4);
    checkOutput("short_halt_a", 32'(halted_a), 32'd0);
    applyStimulus(1, 1, 0, 0, 0, 32'h12345678);

    for (int k = 0; k < 5; k++) applyStimulus(0, 1, 1, 1, 1, 32'h55556666);
    idle(1);
    checkOutput("halt_priority_a", 32'(halted_a), 32'd1);
    applyStimulus(1, 1, 0, 0, 0, 32'h12345678);

    for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0, 0, 0, 32'h77778888);
    idle(1);
    checkOutput("stall_20_a", 32'(stall_a), 32'd20);
    checkOutput("stall_sat_b", 32'(stall_b), 32'hF);
    applyStimulus(1, 1, 0, 0, 0, 32'h12345678);

    hold_left = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold_left == 0 && $urandom_range(0, 19) == 0) hold_left = $urandom_range(1, 6);
      h = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 4) != 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, h, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
